bram_sweep_checker: RTL and testbench
=====================================

BRAM_SWEEP_CHECKER -- requirements
Module: bram_sweep_checker

Interface
REQ-001 Parameter WID_MEM, default 16: memory word width in bits.
REQ-002 Parameter DEPTH_MEM, default 128: number of memory words.
REQ-003 Parameter ADDR_W, default 7: address width; SHALL equal $clog2(DEPTH_MEM).
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset (0 = in reset).
REQ-006 start  input  1: begin a sweep; sampled only in IDLE.
REQ-007 fill  input  1: sampled with start; 1 = write the pattern then verify it, 0 = verify only (checks preloaded init contents).
REQ-008 seed  input  WID_MEM: pattern seed; sampled with start.
REQ-009 mem_raddr  output  ADDR_W: memory read address.
REQ-010 mem_waddr  output  ADDR_W: memory write address.
REQ-011 mem_din  output  WID_MEM: memory write data.
REQ-012 mem_we  output  1: memory write enable.
REQ-013 mem_dout  input  WID_MEM: memory read data, valid 1 cycle after mem_raddr is presented.
REQ-014 busy  output  1: high from the cycle after an accepted start until done.
REQ-015 done  output  1: single-cycle pulse when a sweep completes.
REQ-016 pass  output  1: 1 when the last sweep had zero mismatches; held until the next accepted start.
REQ-017 err_count  output  ADDR_W+1: mismatch count for the current/last sweep.
REQ-018 first_err_valid  output  1: at least one mismatch recorded.
REQ-019 first_err_addr  output  ADDR_W: address of the first mismatch.

Function
REQ-020 pattern(a) SHALL be seed_latched XOR a zero-extended to WID_MEM.
REQ-021 FSM states: IDLE, WRITE, READ, DRAIN, DONE.
REQ-022 IDLE with start=1: latch fill and seed; clear err_count, pass, first_err_valid and first_err_addr; go to WRITE if fill=1, else READ; address counter = 0.
REQ-023 WRITE: one write per cycle; mem_we=1, mem_waddr=cnt, mem_din=pattern(cnt); after cnt=DEPTH_MEM-1, go to READ with cnt=0.
REQ-024 READ: mem_raddr=cnt, one address per cycle; after cnt=DEPTH_MEM-1, go to DRAIN.
REQ-025 The compare stage SHALL delay the read address and a valid bit by 1 cycle, then compare mem_dout against the pattern at the delayed address.
REQ-026 On mismatch: err_count increments; if first_err_valid=0, record the address and set first_err_valid.
REQ-027 DRAIN: one cycle that completes the compare for the last address; then go to DONE.
REQ-028 DONE: assert done for exactly 1 cycle; pass = (err_count==0) including the final compare; return to IDLE.
REQ-029 Latency: fill=1 start-to-done = 2*DEPTH_MEM+3 cycles; fill=0 = DEPTH_MEM+3 cycles (start edge to done-high edge).
REQ-030 mem_we SHALL be 0 in every state except WRITE; mem_raddr/mem_waddr SHALL hold 0 when unused.
REQ-031 start while busy SHALL be ignored, with no effect on the sweep or the latched seed.
REQ-032 The counter SHALL not wrap past DEPTH_MEM-1 within a phase; the last address is compared exactly once.
REQ-033 err_count max is DEPTH_MEM; it needs no saturation.

Reset
REQ-034 reset low SHALL immediately force IDLE, cnt=0, compare valid=0, mem_we=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_addr=0.
REQ-035 A reset during WRITE leaves memory partially written; no recovery is required.
REQ-036 Reset release SHALL be followed by at least one IDLE cycle before start is accepted.

Structure
REQ-037 Package bram_chk_pkg SHALL hold the state enum and the default WID_MEM, DEPTH_MEM and ADDR_W constants.
REQ-038 The compare/record pipeline stage SHALL be the sub-module bram_cmp_stage (inputs: valid, address, expected, dout; outputs: err_count, first_err_*).
REQ-039 The bench SHALL pair the block with a 128x16 simple dual-port BRAM model with read latency 1 plus a write enable.

Verification
REQ-040 fill=1, seed=16'hA5A5 -> done at cycle 259, pass=1, err_count=0, first_err_valid=0.
REQ-041 fill=0, memory preloaded with pattern(seed=16'h0000) except word 0x2A=16'hFFFF -> done at cycle 131, pass=0, err_count=1, first_err_addr=7'h2A.
REQ-042 fill=0, memory words 0x05 and 0x7F corrupted -> err_count=2, first_err_addr=7'h05; the last-address compare is counted in DRAIN.
REQ-043 start pulsed again at cycle 50 of a sweep with a different seed -> ignored; result matches the original seed.
REQ-044 reset asserted mid-READ -> all outputs zero asynchronously; a new fill=0 sweep with a correct image gives pass=1.
REQ-045 All memory-rotated init: every word mismatches -> err_count=128 (8'h80), first_err_addr=0.

Source files
------------

// File: rtl/bram_chk_pkg.sv
// Shared constants and FSM state encoding for the BRAM sweep checker.
package bram_chk_pkg;

  localparam int unsigned WID_MEM_DEF   = 16;
  localparam int unsigned DEPTH_MEM_DEF = 128;
  localparam int unsigned ADDR_W_DEF    = $clog2(DEPTH_MEM_DEF);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/bram_sweep_checker_if.sv
// Control, status and memory-port signals between the sweep checker and its environment.
interface bram_sweep_checker_if
  import bram_chk_pkg::*;
#(
  parameter int unsigned WID_MEM = WID_MEM_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) ();

  logic               start;
  logic               fill;
  logic [WID_MEM-1:0] seed;
  logic [ADDR_W-1:0]  mem_raddr;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [WID_MEM-1:0] mem_din;
  logic               mem_we;
  logic [WID_MEM-1:0] mem_dout;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ADDR_W:0]    err_count;
  logic               first_err_valid;
  logic [ADDR_W-1:0]  first_err_addr;

  modport master (
    input  start, fill, seed, mem_dout,
    output mem_raddr, mem_waddr, mem_din, mem_we,
    output busy, done, pass, err_count, first_err_valid, first_err_addr
  );

  modport slave (
    output start, fill, seed, mem_dout,
    input  mem_raddr, mem_waddr, mem_din, mem_we,
    input  busy, done, pass, err_count, first_err_valid, first_err_addr
  );

endinterface

// File: rtl/bram_cmp_stage.sv
// One-cycle compare stage: aligns read address/expected word with BRAM output and
// accumulates the mismatch count and first failing address.
module bram_cmp_stage
  import bram_chk_pkg::*;
#(
  parameter int unsigned WID_MEM = WID_MEM_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [WID_MEM-1:0] expected_i,
  input  logic [WID_MEM-1:0] dout_i,
  output logic [ADDR_W:0]    err_count_o,
  output logic               first_err_valid_o,
  output logic [ADDR_W-1:0]  first_err_addr_o
);

  logic               valid_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WID_MEM-1:0] exp_q;
  logic [ADDR_W:0]    err_q, err_d;
  logic               fev_q, fev_d;
  logic [ADDR_W-1:0]  fea_q, fea_d;
  logic               mismatch_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
    end else begin
      valid_q <= valid_i;
      addr_q  <= addr_i;
      exp_q   <= expected_i;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
    end
  end

  // Clear wins over a mismatch; only the first failing address is kept.
  always_comb begin
    err_d      = err_q;
    fev_d      = fev_q;
    fea_d      = fea_q;
    mismatch_c = valid_q && (dout_i != exp_q);
    if (clear_i) begin
      err_d = '0;
      fev_d = 1'b0;
      fea_d = '0;
    end else if (mismatch_c) begin
      err_d = err_q + (ADDR_W+1)'(1);
      if (!fev_q) begin
        fev_d = 1'b1;
        fea_d = addr_q;
      end
    end
  end

  assign err_count_o       = err_q;
  assign first_err_valid_o = fev_q;
  assign first_err_addr_o  = fea_q;

endmodule

// File: rtl/bram_sweep_checker.sv
// BRAM sweep checker: optionally writes seed^addr into every word, then reads each
// word back once and reports mismatch count, first failing address and pass/fail.
module bram_sweep_checker
  import bram_chk_pkg::*;
#(
  parameter int unsigned WID_MEM   = WID_MEM_DEF,
  parameter int unsigned DEPTH_MEM = DEPTH_MEM_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  bram_sweep_checker_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [WID_MEM-1:0] seed_q, seed_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [WID_MEM-1:0] din_q, din_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic               rvalid_q, rvalid_d;
  logic               clear_c;
  logic [WID_MEM-1:0] expected_c;
  logic [ADDR_W:0]    err_count_c;
  logic               fev_c;
  logic [ADDR_W-1:0]  fea_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      seed_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      din_q    <= '0;
      raddr_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seed_q   <= seed_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      din_q    <= din_d;
      raddr_q  <= raddr_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Next state; memory-port registers are loaded from the next state so each
  // address reaches the BRAM in the same cycle the FSM is in that phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    clear_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          seed_d  = bus.seed;
          clear_c = 1'b1;
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = bus.fill ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_READ: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_count_c == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d   = (state_d != ST_IDLE);
    we_d     = (state_d == ST_WRITE);
    waddr_d  = we_d ? cnt_d : '0;
    din_d    = we_d ? (seed_d ^ WID_MEM'(cnt_d)) : '0;
    rvalid_d = (state_d == ST_READ);
    raddr_d  = rvalid_d ? cnt_d : '0;
  end

  assign expected_c = seed_q ^ WID_MEM'(raddr_q);

  bram_cmp_stage #(
    .WID_MEM (WID_MEM),
    .ADDR_W  (ADDR_W)
  ) u_cmp (
    .clk               (clk),
    .reset             (reset),
    .clear_i           (clear_c),
    .valid_i           (rvalid_q),
    .addr_i            (raddr_q),
    .expected_i        (expected_c),
    .dout_i            (bus.mem_dout),
    .err_count_o       (err_count_c),
    .first_err_valid_o (fev_c),
    .first_err_addr_o  (fea_c)
  );

  assign bus.mem_raddr       = raddr_q;
  assign bus.mem_waddr       = waddr_q;
  assign bus.mem_din         = din_q;
  assign bus.mem_we          = we_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_count_c;
  assign bus.first_err_valid = fev_c;
  assign bus.first_err_addr  = fea_c;

endmodule

// File: tb/tb_bram_sweep_checker.sv
// Directed bench for bram_sweep_checker paired with a 128x16 dual-port BRAM model.
module tb_bram_sweep_checker;

  logic clk;
  logic reset;

  bram_sweep_checker_if #(.WID_MEM(16), .ADDR_W(7)) bus ();

  bram_sweep_checker #(
    .WID_MEM   (16),
    .DEPTH_MEM (128),
    .ADDR_W    (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem   [128];
  logic [15:0] img   [128];
  logic [15:0] dout_q;
  logic        load_req;

  // BRAM model: read latency 1; load_req copies the staged image in one cycle.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 128; i++) mem[i] <= img[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_waddr] <= bus.mem_din;
    end
    dout_q <= mem[bus.mem_raddr];
  end
  assign bus.mem_dout = dout_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fill;
    logic [15:0] seed;
    int          mode;      // 0: keep memory, 1: pattern image, 2: rotated image
    logic [15:0] img_seed;
    int          nbad;
    int          bad0;
    int          bad1;
    logic        exp_pass;
    int          exp_err;
    logic        exp_fev;
    int          exp_fea;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs [8];
  int   total;
  int   bad;

  function automatic logic [15:0] pat(input logic [15:0] s, input int a);
    return s ^ 16'(a);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic load_image(input int mode, input logic [15:0] s, input int nbad,
                            input int b0, input int b1);
    for (int i = 0; i < 128; i++)
      img[i] = (mode == 2) ? pat(s, (i + 1) % 128) : pat(s, i);
    if (nbad >= 1) img[b0] = 16'hFFFF;
    if (nbad >= 2) img[b1] = 16'hFFFF;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int inj_cyc, input logic [15:0] inj_seed,
                         input string tag);
    int cyc;
    int wec;
    bit got;
    if (v.mode != 0) load_image(v.mode, v.img_seed, v.nbad, v.bad0, v.bad1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.fill  = v.fill;
    bus.seed  = v.seed;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.seed  = 16'h0;
    cyc = 1;
    wec = int'(bus.mem_we);
    got = 1'b0;
    chk({tag, ".busy_on"}, int'(bus.busy), 1);
    while (!got && cyc < 1000) begin
      if (cyc == inj_cyc) begin
        bus.start = 1'b1;
        bus.fill  = 1'b0;
        bus.seed  = inj_seed;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc++;
      if (bus.done) got = 1'b1;
      else if (bus.mem_we) wec++;
    end
    chk({tag, ".latency"}, got ? cyc : -1, v.exp_lat);
    chk({tag, ".pass"}, int'(bus.pass), int'(v.exp_pass));
    chk({tag, ".err_count"}, int'(bus.err_count), v.exp_err);
    chk({tag, ".first_err_valid"}, int'(bus.first_err_valid), int'(v.exp_fev));
    chk({tag, ".first_err_addr"}, int'(bus.first_err_addr), v.exp_fea);
    chk({tag, ".we_cycles"}, wec, v.exp_we);
    chk({tag, ".busy_at_done"}, int'(bus.busy), 0);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, int'(bus.done), 0);
    chk({tag, ".pass_held"}, int'(bus.pass), int'(v.exp_pass));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, int'(bus.busy), 0);
    chk({tag, ".done"}, int'(bus.done), 0);
    chk({tag, ".pass"}, int'(bus.pass), 0);
    chk({tag, ".err_count"}, int'(bus.err_count), 0);
    chk({tag, ".first_err_valid"}, int'(bus.first_err_valid), 0);
    chk({tag, ".first_err_addr"}, int'(bus.first_err_addr), 0);
    chk({tag, ".mem_we"}, int'(bus.mem_we), 0);
    chk({tag, ".mem_raddr"}, int'(bus.mem_raddr), 0);
    chk({tag, ".mem_waddr"}, int'(bus.mem_waddr), 0);
  endtask

  initial begin
    vec_t v;
    int   cyc;
    total    = 0;
    bad      = 0;
    load_req = 1'b0;
    bus.start = 1'b0;
    bus.fill  = 1'b0;
    bus.seed  = 16'h0;
    for (int i = 0; i < 128; i++) img[i] = 16'h0;

    //          fill  seed     mode img_seed nbad b0     b1     pass err  fev  fea    lat  we
    vecs[0] = '{1'b1, 16'hA5A5, 0, 16'h0000, 0, 0,     0,     1'b1, 0,   1'b0, 0,     259, 128};
    vecs[1] = '{1'b0, 16'hA5A5, 0, 16'h0000, 0, 0,     0,     1'b1, 0,   1'b0, 0,     131, 0};
    vecs[2] = '{1'b0, 16'h0000, 1, 16'h0000, 1, 'h2A,  0,     1'b0, 1,   1'b1, 'h2A,  131, 0};
    vecs[3] = '{1'b0, 16'h1234, 1, 16'h1234, 2, 'h05,  'h7F,  1'b0, 2,   1'b1, 'h05,  131, 0};
    vecs[4] = '{1'b0, 16'h0F0F, 2, 16'h0F0F, 0, 0,     0,     1'b0, 128, 1'b1, 0,     131, 0};
    vecs[5] = '{1'b0, 16'h00FF, 1, 16'h00FF, 1, 'h7F,  0,     1'b0, 1,   1'b1, 'h7F,  131, 0};
    vecs[6] = '{1'b1, 16'hFFFF, 0, 16'h0000, 0, 0,     0,     1'b1, 0,   1'b0, 0,     259, 128};
    vecs[7] = '{1'b0, 16'hFFFF, 0, 16'h0000, 0, 0,     0,     1'b1, 0,   1'b0, 0,     131, 0};

    reset = 1'b1;
    #2 reset = 1'b0;
    #1 chk_all_zero("reset_async");
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset_held");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 8; k++) run_vec(vecs[k], -1, 16'h0, $sformatf("vec%0d", k));

    // Second start during a fill sweep must not disturb it.
    v = '{1'b1, 16'h1111, 0, 16'h0000, 0, 0, 0, 1'b1, 0, 1'b0, 0, 259, 128};
    run_vec(v, 50, 16'h2222, "restart_ignored");
    v = '{1'b0, 16'h1111, 0, 16'h0000, 0, 0, 0, 1'b1, 0, 1'b0, 0, 131, 0};
    run_vec(v, -1, 16'h0, "restart_verify");

    // Reset in the middle of a read phase that has already logged a mismatch.
    load_image(1, 16'h3C3C, 1, 'h05, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.fill  = 1'b0;
    bus.seed  = 16'h3C3C;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 60) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("mid_read.busy_before", int'(bus.busy), 1);
    chk("mid_read.err_before", int'(bus.err_count), 1);
    chk("mid_read.fea_before", int'(bus.first_err_addr), 'h05);
    #2 reset = 1'b0;
    #1 chk_all_zero("mid_read_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    v = '{1'b0, 16'h3C3C, 1, 16'h3C3C, 0, 0, 0, 1'b1, 0, 1'b0, 0, 131, 0};
    run_vec(v, -1, 16'h0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
